// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO, MADD/MSUB and MTHI/MTLO; WIDTH+1 cycles for arithmetic ops, 1 cycle for moves and divide-by-zero.
// No queueing: Start is only sampled while idle, so callers stall on Busy and resume on Done.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          cnt;
    logic [2*WIDTH-1:0]     work;
    logic [WIDTH-1:0]       opb;
    logic [2:0]             op_q;
    logic                   neg_res;
    logic                   neg_rem;

    logic                   accept;
    logic                   is_div_in;
    logic                   is_move_in;
    logic                   div_zero;
    logic                   go_iter;
    logic                   signed_in;
    logic                   a_neg;
    logic                   b_neg;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   op_q_is_div;
    logic [WIDTH:0]         mul_upper;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     div_next;
    logic [2*WIDTH-1:0]     prod;
    logic [2*WIDTH-1:0]     hilo;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;

    // Operand decode and magnitude extraction at the accept edge.
    always_comb begin
        accept     = Start && (state == IDLE);
        is_div_in  = (Op == OP_DIV) || (Op == OP_DIVU);
        is_move_in = (Op == OP_MTHI) || (Op == OP_MTLO);
        div_zero   = accept && is_div_in && (B == '0);
        go_iter    = accept && !is_move_in && !div_zero;
        signed_in  = (Op == OP_MULT) || (Op == OP_DIV) || (Op == OP_MADD) || (Op == OP_MSUB);
        a_neg      = signed_in && A[WIDTH-1];
        b_neg      = signed_in && B[WIDTH-1];
        a_mag      = a_neg ? (-A) : A;
        b_mag      = b_neg ? (-B) : B;
    end

    // One iteration step; work holds {partial product | remainder, multiplier | quotient}.
    always_comb begin
        op_q_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
        mul_upper   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opb} : '0);
        mul_next    = {mul_upper, work[WIDTH-1:1]};
        div_shift   = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff    = div_shift - {1'b0, opb};
        div_next    = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
        prod        = neg_res ? (-work) : work;
        hilo        = {Hi, Lo};
        quot        = neg_res ? (-work[WIDTH-1:0]) : work[WIDTH-1:0];
        rem         = neg_rem ? (-work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go_iter) state_nxt = CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            opb       <= '0;
            op_q      <= '0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= Op;
                        opb     <= b_mag;
                        work    <= {{WIDTH{1'b0}}, a_mag};
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= CW'(WIDTH);
                        if (div_zero) begin
                            Done      <= 1'b1;
                            DivByZero <= 1'b1;
                        end else if (Op == OP_MTHI) begin
                            Hi   <= A;
                            Done <= 1'b1;
                        end else if (Op == OP_MTLO) begin
                            Lo   <= A;
                            Done <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    cnt  <= cnt - CW'(1);
                    work <= op_q_is_div ? div_next : mul_next;
                end
                FINISH: begin
                    Done <= 1'b1;
                    case (op_q)
                        OP_DIV, OP_DIVU: begin
                            Hi <= rem;
                            Lo <= quot;
                        end
                        OP_MADD:  {Hi, Lo} <= hilo + prod;
                        OP_MSUB:  {Hi, Lo} <= hilo - prod;
                        default:  {Hi, Lo} <= prod;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: directed ops push expectations, a negedge monitor pops on Done.
module tb_muldiv_hilo_unit;

    localparam int W = 32;

    logic          Clk;
    logic          Rst;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Busy;
    logic          Done;
    logic          DivByZero;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;

    muldiv_hilo_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          busy;
        int          t0;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          busy_run = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: negedge count since the Start drive gives latency (short ops 1, iterative W+2).
    always @(negedge Clk) begin
        exp_t e;
        ncyc = ncyc + 1;
        if (Rst) begin
            busy_run = 0;
        end else begin
            if (Busy) begin
                busy_run++;
                if (!Done) begin
                    chk("hold_hi", Hi, prev_hi);
                    chk("hold_lo", Lo, prev_lo);
                end
            end
            if (DivByZero && !Done) flag("dbz_without_done");
            if (Done) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, Hi, e.hi);
                    chk({e.name, "_lo"}, Lo, e.lo);
                    chk({e.name, "_dbz"}, 32'(DivByZero), 32'(e.dbz));
                    chk({e.name, "_lat"}, 32'(ncyc - e.t0), 32'(e.lat));
                    chk({e.name, "_busy"}, 32'(busy_run), 32'(e.busy));
                end
                busy_run = 0;
            end
        end
        prev_hi = Hi;
        prev_lo = Lo;
    end

    // Called just after a negedge; returns just after the next negedge.
    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edbz);
        exp_t e;
        bit   iter;
        iter   = !(op == 3'b100 || op == 3'b101) && !edbz;
        Start  = 1'b1;
        Op     = op;
        A      = a;
        B      = b;
        e.hi   = eh;
        e.lo   = el;
        e.dbz  = edbz;
        e.lat  = iter ? W + 2 : 1;
        e.busy = iter ? W + 1 : 0;
        e.t0   = ncyc;
        e.name = name;
        exp_q.push_back(e);
        @(negedge Clk); #1;
        Start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge Clk); #1;
        end
        if (exp_q.size() != 0) begin
            flag("timeout_waiting_done");
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        Rst   = 1'b1;
        Start = 1'b0;
        Op    = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_dbz", 32'(DivByZero), 32'h0);
        Rst = 1'b0;
        @(negedge Clk); #1;

        issue("mthi_pre", 3'b100, 32'h1234, 32'h0, 32'h1234, 32'h0, 1'b0);            wait_idle();
        issue("mtlo_pre", 3'b101, 32'h5678, 32'h0, 32'h1234, 32'h5678, 1'b0);         wait_idle();
        issue("divu_zero", 3'b011, 32'h9, 32'h0, 32'h1234, 32'h5678, 1'b1);           wait_idle();
        issue("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0); wait_idle();
        issue("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b0); wait_idle();
        issue("mult_min", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0); wait_idle();
        issue("div_neg", 3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);  wait_idle();
        issue("divu_7_2", 3'b011, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0);                   wait_idle();
        issue("div_wrap", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0); wait_idle();
        issue("mthi_0", 3'b100, 32'h0, 32'h0, 32'h0, 32'h80000000, 1'b0);              wait_idle();
        issue("mtlo_10", 3'b101, 32'd10, 32'h0, 32'h0, 32'd10, 1'b0);                  wait_idle();
        issue("madd", 3'b110, 32'd3, 32'd4, 32'h0, 32'd22, 1'b0);                      wait_idle();
        issue("msub", 3'b111, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);         wait_idle();

        // Start pulse while busy must be dropped; no expectation is pushed for it.
        issue("multu_ign", 3'b001, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
        repeat (4) begin @(negedge Clk); #1; end
        Start = 1'b1;
        Op    = 3'b101;
        A     = 32'd99;
        @(negedge Clk); #1;
        Start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (Done) seen = 1'b1;
            else begin @(negedge Clk); #1; end
        end
        if (!seen) flag("timeout_multu_ign");
        // Issued in the Done cycle: must be accepted immediately.
        issue("divu_b2b", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_idle();

        // Reset mid-operation.
        Start = 1'b1;
        Op    = 3'b001;
        A     = 32'd6;
        B     = 32'd7;
        @(negedge Clk); #1;
        Start = 1'b0;
        repeat (9) begin @(negedge Clk); #1; end
        chk("pre_rst_busy", 32'(Busy), 32'h1);
        #2;
        Rst = 1'b1;
        #1;
        chk("arst_busy", 32'(Busy), 32'h0);
        chk("arst_done", 32'(Done), 32'h0);
        chk("arst_hi", Hi, 32'h0);
        chk("arst_lo", Lo, 32'h0);
        @(negedge Clk); #1;
        Rst = 1'b0;
        repeat (40) begin @(negedge Clk); #1; end
        issue("mult_post_rst", 3'b000, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);
        wait_idle();

        repeat (5) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit with integrated HI/LO registers.
- Generalises the single-cycle ALU-plus-HiLo path: iterative shift-add multiply and restoring divide over WIDTH cycles, plus MADD/MSUB accumulate and MTHI/MTLO moves.
- Sits beside the ALU; a start/busy/done handshake lets a multi-cycle or pipelined datapath stall on it.

Parameters:
- WIDTH, 32: operand and HI/LO register width in bits; must be at least 4.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD (signed), 111 MSUB (signed).
- A  input  WIDTH  operand A: multiplicand, dividend, or move source.
- B  input  WIDTH  operand B: multiplier or divisor.
- Busy  output  1  high while an iterative operation is in flight.
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result in the same cycle.
- DivByZero  output  1  one-cycle pulse coincident with Done for DIV/DIVU with B=0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): state IDLE; Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0. Reset mid-operation aborts the operation with no partial write.
- States:
  - IDLE: accept Start.
  - CALC: exactly WIDTH iterations, one bit per cycle.
  - FINISH: one cycle; apply sign correction and accumulate; write Hi/Lo.
  - Return to IDLE after FINISH.
- Acceptance:
  - Start is accepted at a rising edge only if state is IDLE.
  - At acceptance, A, B and Op are latched internally; later changes to the inputs are ignored.
  - Start while Busy=1 is ignored and not queued.
- Iterative ops (MULT, MULTU, DIV, DIVU with B≠0, MADD, MSUB):
  - Accept edge k; Busy=1 after edges k through k+WIDTH.
  - Hi/Lo are written at edge k+WIDTH+1.
  - After that edge: Done=1 and Busy=0.
  - Total latency is WIDTH+1 cycles.
  - Start with Done high is accepted, so back-to-back operations are allowed.
- Signed handling: magnitudes are computed on absolute values; negation is applied in FINISH. |-2^(WIDTH-1)| is handled as unsigned 2^(WIDTH-1).
- MULT/MULTU: {Hi,Lo} = full 2·WIDTH-bit product.
- MADD/MSUB: {Hi,Lo} = {Hi,Lo} ± signed product, modulo 2^(2·WIDTH). Uses the Hi/Lo values present at FINISH.
- DIV/DIVU:
  - Lo = quotient, Hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 gives Lo = -2^(WIDTH-1), Hi = 0 (wrap, no flag).
- Divide by zero:
  - No iteration; Busy stays 0.
  - Hi/Lo are unchanged.
  - Done and DivByZero pulse in the cycle after the accept edge.
- MTHI/MTLO:
  - Single cycle, Busy stays 0.
  - Hi (or Lo) takes A at the accept edge; the other register is unchanged.
  - Done pulses in the next cycle.
- Outputs: Hi/Lo hold their previous values throughout CALC; no intermediate values are visible. Done and DivByZero are registered.
- Iteration counter: $clog2(WIDTH)+1 bits, counting down from WIDTH to 0.

Test Plan:
All values WIDTH=32, start edge = k.
- MULT A=0xFFFFFFFD (-3), B=5 → Busy high for 33 cycles; at k+33 Hi=0xFFFFFFFF, Lo=0xFFFFFFF1, Done pulses once.
- MULTU A=B=0xFFFFFFFF → Hi=0xFFFFFFFE, Lo=0x00000001. Also MULT A=0x80000000, B=0x80000000 → Hi=0x40000000, Lo=0.
- DIV A=0xFFFFFFF9 (-7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIVU A=7, B=2 → Lo=3, Hi=1. Then DIV A=0x80000000, B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Preload Hi=0x1234, Lo=0x5678, then DIVU A=9, B=0 → Done and DivByZero high at k+1, Busy never high, Hi/Lo still 0x1234/0x5678.
- MTHI A=0, MTLO A=10, then MADD A=3, B=4 → Hi=0, Lo=22. Then MSUB A=5, B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFFD.
- Start MULTU 6×7. Pulse Start with Op=MTLO at k+5 → ignored; result Lo=42.
- Restart the same MULTU and assert Rst at k+10 → Busy, Done, Hi and Lo all drop to 0 without waiting for a clock edge. After release, a new MULT 2×3 gives Lo=6 at 33 cycles.
